// File: rtl/pipe_adder_pkg.sv
// -----------------------------------------------------------------------------
// pipe_adder_pkg
// Shared constants and types for the skewed pipelined adder.
//   DEFAULT_WIDTH / DEFAULT_STAGES : default operand width and pipeline depth
//   PAYLOAD_W                      : width of the sum field carried per stage
//   stage_t                        : per-stage payload (valid, carry, sum chunks)
// The stage_t sum field is PAYLOAD_W bits wide, so a pipe_adder instance must
// use WIDTH <= PAYLOAD_W. Only the low WIDTH bits are meaningful.
// -----------------------------------------------------------------------------
package pipe_adder_pkg;

  localparam int DEFAULT_WIDTH  = 32;
  localparam int DEFAULT_STAGES = 4;
  localparam int PAYLOAD_W      = DEFAULT_WIDTH;

  // One pipeline stage: the sum chunks completed so far, the carry out of the
  // most recent chunk, and whether the stage holds a live transaction.
  typedef struct packed {
    logic                 valid;
    logic                 carry;
    logic [PAYLOAD_W-1:0] sum;
  } stage_t;

endpackage : pipe_adder_pkg

// File: rtl/pipe_adder_if.sv
// -----------------------------------------------------------------------------
// pipe_adder_if
// Valid/ready operand and result channels of pipe_adder.
//   Operand side : in_valid, in_ready, a, b, cin
//   Result side  : out_valid, out_ready, sum, cout, ovf
// Modports:
//   master : drives operands and out_ready (the environment)
//   slave  : the adder itself
// -----------------------------------------------------------------------------
interface pipe_adder_if
  import pipe_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );

endinterface : pipe_adder_if

// File: rtl/pipe_adder_chunk.sv
// -----------------------------------------------------------------------------
// adder_chunk
// CW-bit combinational ripple-carry adder built from full-adder cells.
//   a, b   : chunk operands
//   ci     : carry into bit 0
//   s      : chunk sum
//   co     : carry out of bit CW-1
//   msb_ci : carry into bit CW-1 (used for signed overflow on the top chunk)
// -----------------------------------------------------------------------------
module adder_chunk
  import pipe_adder_pkg::*;
#(
  parameter int CW = DEFAULT_WIDTH / DEFAULT_STAGES
) (
  input  logic [CW-1:0] a,
  input  logic [CW-1:0] b,
  input  logic          ci,
  output logic [CW-1:0] s,
  output logic          co,
  output logic          msb_ci
);

  logic [CW:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < CW; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign co     = c[CW];
  assign msb_ci = c[CW-1];

endmodule : adder_chunk

// File: rtl/pipe_adder.sv
// -----------------------------------------------------------------------------
// pipe_adder
// Skewed pipelined adder: sum = a + b + cin (mod 2^WIDTH), one CW-bit chunk
// added per stage, CW = WIDTH / STAGES (WIDTH must be a multiple of STAGES and
// no wider than pipe_adder_pkg::PAYLOAD_W).
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-high; clears every stage
//   bus   : pipe_adder_if.slave (operand and result valid/ready channels)
// Optional feature: define PIPE_ADDER_OVF_EN to register a signed-overflow flag
// alongside the sum; otherwise ovf is tied low and no overflow register exists.
// Stage k adds operand chunk k with the carry from stage k-1. Operand words
// travel forward with the transaction so later stages find their chunk, and
// completed low sum chunks travel forward in the stage payload.
// -----------------------------------------------------------------------------
module pipe_adder
  import pipe_adder_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int STAGES = DEFAULT_STAGES
) (
  input  logic        clk,
  input  logic        reset,
  pipe_adder_if.slave bus
);

  localparam int CW   = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  stage_t               st_q     [STAGES];
  stage_t               st_d     [STAGES];
  logic [WIDTH-1:0]     opa_q    [STAGES];
  logic [WIDTH-1:0]     opb_q    [STAGES];
  logic [WIDTH-1:0]     opa_d    [STAGES];
  logic [WIDTH-1:0]     opb_d    [STAGES];
  logic [WIDTH-1:0]     src_a    [STAGES];
  logic [WIDTH-1:0]     src_b    [STAGES];
  logic [PAYLOAD_W-1:0] base_sum [STAGES];
  logic [CW-1:0]        ch_s     [STAGES];
  logic [STAGES-1:0]    adv;
  logic [STAGES-1:0]    up_valid;
  logic [STAGES-1:0]    ch_ci;
  logic [STAGES-1:0]    ch_co;
  logic [STAGES-1:0]    ch_msb;

  // A stage may take new contents when it is empty or its occupant moves on;
  // the chain starts at the output, where the occupant leaves on out_ready.
  always_comb begin : p_advance
    adv       = '0;
    adv[LAST] = !st_q[LAST].valid || bus.out_ready;
    for (int k = LAST - 1; k >= 0; k--) begin
      adv[k] = !st_q[k].valid || adv[k+1];
    end
  end

  // Per-stage operand sources and chunk arithmetic.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign src_a[k]    = bus.a;
      assign src_b[k]    = bus.b;
      assign ch_ci[k]    = bus.cin;
      assign up_valid[k] = bus.in_valid;
      assign base_sum[k] = '0;
    end else begin : g_body
      assign src_a[k]    = opa_q[k-1];
      assign src_b[k]    = opb_q[k-1];
      assign ch_ci[k]    = st_q[k-1].carry;
      assign up_valid[k] = st_q[k-1].valid;
      assign base_sum[k] = st_q[k-1].sum;
    end

    adder_chunk #(.CW(CW)) u_chunk (
      .a      (src_a[k][k*CW +: CW]),
      .b      (src_b[k][k*CW +: CW]),
      .ci     (ch_ci[k]),
      .s      (ch_s[k]),
      .co     (ch_co[k]),
      .msb_ci (ch_msb[k])
    );
  end

  always_comb begin : p_next
    for (int k = 0; k < STAGES; k++) begin
      // NOTE: hold values are assigned first so every path drives every bit;
      // a path that left st_d unassigned would infer a latch.
      st_d[k]  = st_q[k];
      opa_d[k] = opa_q[k];
      opb_d[k] = opb_q[k];
      if (adv[k]) begin
        st_d[k].valid = up_valid[k];
        if (up_valid[k]) begin
          st_d[k].sum             = base_sum[k];
          st_d[k].sum[k*CW +: CW] = ch_s[k];
          st_d[k].carry           = ch_co[k];
          opa_d[k]                = src_a[k];
          opb_d[k]                = src_b[k];
        end
      end
    end
  end

  // The last stage needs no operand copy: nothing downstream reads it.
  always_ff @(posedge clk or posedge reset) begin : p_regs
    if (reset) begin
      // NOTE: the pipeline data is cleared along with the valid bits so sum and
      // cout read zero during reset rather than stale in-flight values.
      for (int k = 0; k < STAGES; k++) begin
        st_q[k] <= '0;
      end
      for (int k = 0; k < LAST; k++) begin
        opa_q[k] <= '0;
        opb_q[k] <= '0;
      end
    end else begin
      // NOTE: non-blocking updates make every stage sample the pre-edge value
      // of its predecessor, which is what lets all stages shift in one cycle.
      for (int k = 0; k < STAGES; k++) begin
        st_q[k] <= st_d[k];
      end
      for (int k = 0; k < LAST; k++) begin
        opa_q[k] <= opa_d[k];
        opb_q[k] <= opb_d[k];
      end
    end
  end

  // The MSB carry-in is only meaningful for the top chunk; the other chunks'
  // copies are folded into a sink.
  logic unused_msb;
  assign unused_msb = ^ch_msb;

`ifdef PIPE_ADDER_OVF_EN
  logic ovf_q;
  logic ovf_d;

  // Overflow is computed where the top chunk is added and rides with the
  // final stage, so it is aligned with sum and cout.
  always_comb begin : p_ovf_next
    ovf_d = ovf_q;
    if (adv[LAST] && up_valid[LAST]) begin
      ovf_d = ch_msb[LAST] ^ ch_co[LAST];
    end
  end

  always_ff @(posedge clk or posedge reset) begin : p_ovf_reg
    if (reset) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign bus.ovf = ovf_q;
`else
  assign bus.ovf = 1'b0;
`endif

  assign bus.in_ready  = adv[0];
  assign bus.out_valid = st_q[LAST].valid;
  assign bus.sum       = st_q[LAST].sum[WIDTH-1:0];
  assign bus.cout      = st_q[LAST].carry;

endmodule : pipe_adder

// File: tb/tb_pipe_adder.sv
// -----------------------------------------------------------------------------
// tb_pipe_adder
// Self-checking bench for pipe_adder (WIDTH=32, STAGES=4). A transaction-level
// model (plain 33-bit addition, signed overflow from operand/result signs, an
// in-order queue and an occupancy count) is compared with the DUT on every
// falling edge; directed tests pin the model with literal expectations.
// Build with +define+PIPE_ADDER_OVF_EN to exercise the overflow flag.
// -----------------------------------------------------------------------------
module tb_pipe_adder;
  import pipe_adder_pkg::*;

  localparam int WIDTH  = 32;
  localparam int STAGES = 4;

`ifdef PIPE_ADDER_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    int          acc_edge;
    int          ret_edge;
  } res_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  pipe_adder_if #(.WIDTH(WIDTH)) bus ();

  pipe_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int   checks    = 0;
  int   failures  = 0;
  int   cyc       = 0;
  int   occ       = 0;
  int   acc_cnt   = 0;
  int   ret_cnt   = 0;
  bit   prev_hold = 1'b0;
  res_t exp_q[$];
  res_t got_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic ci);
    res_t        r;
    logic [32:0] full;
    full       = {1'b0, a} + {1'b0, b} + {32'd0, ci};
    r.sum      = full[31:0];
    r.cout     = full[32];
    r.ovf      = OVF_EN && (a[31] == b[31]) && (r.sum[31] != a[31]);
    r.acc_edge = 0;
    r.ret_edge = 0;
    return r;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Compare process: on each falling edge, check the DUT against the model and
  // record what the next rising edge will accept and retire.
  initial forever begin
    res_t r;
    @(negedge clk);
    if (reset) begin
      exp_q.delete();
      occ       = 0;
      prev_hold = 1'b0;
    end else begin
      check("in_ready", bus.in_ready, (occ == STAGES && !bus.out_ready) ? 1'b0 : 1'b1);
      if (prev_hold) check("hold_out_valid", bus.out_valid, 1'b1);
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_result", bus.out_valid, 1'b0);
        end else begin
          check("sum", bus.sum, exp_q[0].sum);
          check("cout", bus.cout, exp_q[0].cout);
          check("ovf", bus.ovf, exp_q[0].ovf);
          if (bus.out_ready) begin
            r          = exp_q.pop_front();
            r.sum      = bus.sum;
            r.cout     = bus.cout;
            r.ovf      = bus.ovf;
            r.ret_edge = cyc + 1;
            got_q.push_back(r);
            occ--;
            ret_cnt++;
          end
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        r          = model(bus.a, bus.b, bus.cin);
        r.acc_edge = cyc + 1;
        exp_q.push_back(r);
        occ++;
        acc_cnt++;
      end
      prev_hold = bus.out_valid && !bus.out_ready;
    end
  end

  initial begin
    #800_000;
    $display("FAIL watchdog: time limit reached, got %0d want finished", cyc);
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one operand set and hold it until accepted (bounded).
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic ci);
    int n;
    n            = 0;
    bus.in_valid = 1'b1;
    bus.a        = a;
    bus.b        = b;
    bus.cin      = ci;
    #1;
    while (!bus.in_ready && n < 50) begin
      tick();
      n++;
    end
    if (n == 50) check("send_timeout", bus.in_ready, 1'b1);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_results(input int n, input int budget);
    int k;
    k = 0;
    while (got_q.size() < n && k < budget) begin
      tick();
      k++;
    end
    check("result_count", got_q.size(), n);
  endtask

  initial begin
    int          base;
    int          acc_base;
    int          ret_base;
    int          k;
    int          sel;
    logic [31:0] stall_sum [5];

    stall_sum = '{32'h1111_1111, 32'h2222_2223, 32'h3333_3335, 32'h4444_4447, 32'h5555_5559};

    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) tick();

    // Reset state.
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_sum", bus.sum, 32'h0);
    check("rst_cout", bus.cout, 1'b0);
    check("rst_ovf", bus.ovf, 1'b0);
    check("rst_in_ready", bus.in_ready, 1'b1);
    reset = 1'b0;
    tick();
    bus.out_ready = 1'b1;

    // Carry ripples through every chunk.
    base = got_q.size();
    send(32'hFFFF_FFFF, 32'h0, 1'b1);
    wait_results(base + 1, 20);
    if (got_q.size() > base) begin
      check("t1_sum", got_q[base].sum, 32'h0000_0000);
      check("t1_cout", got_q[base].cout, 1'b1);
      check("t1_ovf", got_q[base].ovf, 1'b0);
      check("t1_latency", got_q[base].ret_edge - got_q[base].acc_edge, STAGES);
    end

    // Signed overflow.
    base = got_q.size();
    send(32'h7FFF_FFFF, 32'h1, 1'b0);
    wait_results(base + 1, 20);
    if (got_q.size() > base) begin
      check("t2_sum", got_q[base].sum, 32'h8000_0000);
      check("t2_cout", got_q[base].cout, 1'b0);
      check("t2_ovf", got_q[base].ovf, OVF_EN);
    end

    // Eight back-to-back operand sets, one result per cycle.
    base = got_q.size();
    for (int i = 0; i < 8; i++) send(32'(i), 32'(16 * i), 1'b0);
    wait_results(base + 8, 40);
    if (got_q.size() >= base + 8) begin
      for (int i = 0; i < 8; i++) begin
        check("t3_sum", got_q[base+i].sum, 32'(17 * i));
        check("t3_latency", got_q[base+i].ret_edge - got_q[base+i].acc_edge, STAGES);
        if (i > 0) begin
          check("t3_acc_gap", got_q[base+i].acc_edge - got_q[base+i-1].acc_edge, 1);
          check("t3_ret_gap", got_q[base+i].ret_edge - got_q[base+i-1].ret_edge, 1);
        end
      end
    end

    // Stall: fill the pipe with out_ready low, then release it.
    base          = got_q.size();
    bus.out_ready = 1'b0;
    acc_base      = acc_cnt;
    for (int i = 0; i < 4; i++) send(32'h1111_1111 * (i + 1), 32'(i), 1'b0);
    bus.in_valid = 1'b1;
    bus.a        = 32'h5555_5555;
    bus.b        = 32'h4;
    bus.cin      = 1'b0;
    repeat (4) tick();
    check("t4_accepts", acc_cnt - acc_base, 4);
    check("t4_in_ready_full", bus.in_ready, 1'b0);
    check("t4_out_valid", bus.out_valid, 1'b1);
    check("t4_held_sum", bus.sum, stall_sum[0]);
    check("t4_no_retire", got_q.size(), base);
    bus.out_ready = 1'b1;
    #1;
    check("t4_in_ready_shift", bus.in_ready, 1'b1);
    tick();
    bus.in_valid = 1'b0;
    wait_results(base + 5, 30);
    if (got_q.size() >= base + 5) begin
      for (int i = 0; i < 5; i++) check("t4_sum", got_q[base+i].sum, stall_sum[i]);
      check("t4_same_edge", got_q[base+4].acc_edge, got_q[base].ret_edge);
    end

    // Reset with transactions in flight.
    base = got_q.size();
    for (int i = 0; i < 3; i++) send(32'hA000_0000 + 32'(i), 32'h1, 1'b0);
    tick();
    check("t5_pre_out_valid", bus.out_valid, 1'b1);
    reset = 1'b1;
    #1;
    check("t5_out_valid", bus.out_valid, 1'b0);
    check("t5_sum", bus.sum, 32'h0);
    check("t5_cout", bus.cout, 1'b0);
    check("t5_in_ready", bus.in_ready, 1'b1);
    repeat (2) tick();
    reset = 1'b0;
    repeat (20) tick();
    check("t5_no_stale", got_q.size(), base);

    // Random operands with random valid/ready.
    acc_base = acc_cnt;
    ret_base = ret_cnt;
    k        = 0;
    while (acc_cnt - acc_base < 10000 && k < 40000) begin
      sel           = $urandom_range(0, 7);
      bus.in_valid  = ($urandom_range(0, 9) < 7);
      bus.a         = (sel == 0) ? 32'hFFFF_FFFF : (sel == 1) ? 32'h7FFF_FFFF : $urandom;
      bus.b         = (sel == 2) ? 32'h8000_0000 : $urandom;
      bus.cin       = 1'($urandom_range(0, 1));
      bus.out_ready = ($urandom_range(0, 9) < 7);
      tick();
      k++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    check("t6_accepts", acc_cnt - acc_base, 10000);
    k = 0;
    while (exp_q.size() != 0 && k < 50) begin
      tick();
      k++;
    end
    check("t6_drained", exp_q.size(), 0);
    check("t6_retires", ret_cnt - ret_base, 10000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_pipe_adder
